// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out shifter with ready/valid handshake.
//
// A WIDTH-bit word is captured when ld=1 while idle and is streamed out MSB
// first, one bit per accepted handshake (ser_valid & ser_ready). After the last
// bit is accepted, done pulses for one cycle, then the block returns to idle.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   data_in    in   WIDTH  parallel word to serialize
//   ld         in   1      load request, honoured only while idle
//   ser_ready  in   1      downstream accepts the current bit
//   ser_out    out  1      current serial bit (0 when not valid)
//   ser_valid  out  1      ser_out holds a valid bit
//   busy       out  1      word in flight or completion being signalled
//   done       out  1      one-cycle pulse after the last bit is accepted
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;

  logic w_load;
  logic w_accept;
  logic w_last;

  assign w_load   = (r_state == IDLE) && ld;
  assign w_accept = (r_state == SHIFT) && ser_ready;
  assign w_last   = (r_cnt == LAST);

  // Next state and Moore outputs.
  always_comb begin
    w_state_nxt = r_state;
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (ld) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_out   = r_shift[WIDTH-1];
        if (ser_ready && w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_shift <= data_in;
        r_cnt   <= '0;
      end else if (w_accept) begin
        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
        // Saturate at the last index; the transition to DONE ends the word.
        if (!w_last) r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule
